// File: rtl/lut_req_arb_pkg.sv
// -----------------------------------------------------------------------------
// lut_req_arb_pkg
// Shared definitions for the LUT request arbiter:
//   - algorithm mode encodings (ALG_SPN8, ALG_SPN16)
//   - FSM state encoding (lut_state_e)
//   - address / data / lookup-input widths
//   - lut_xlat(): maps a lookup input value to a RAM word address and a
//     byte-select, flagging unsupported modes.
// -----------------------------------------------------------------------------
package lut_req_arb_pkg;

  localparam int LUT_ADDR_W = 13;
  localparam int LUT_DATA_W = 128;
  localparam int LUT_IN_W   = 16;
  localparam int LUT_MODE_W = 3;
  localparam int LUT_STAT_W = 16;

  localparam logic [LUT_MODE_W-1:0] ALG_SPN8  = 3'b000;
  localparam logic [LUT_MODE_W-1:0] ALG_SPN16 = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GEN  = 2'b01,
    ST_RUN  = 2'b10
  } lut_state_e;

  typedef struct packed {
    logic [LUT_ADDR_W-1:0] addr;
    logic [3:0]            bs;
    logic                  err;
  } lut_xlat_t;

  // spn8 : 16 bytes per word, 16 words used (a[7:4] word, a[3:0] byte).
  // spn16: 8 halfwords per word (a[15:3] word, a[2:0] halfword).
  function automatic lut_xlat_t lut_xlat(input logic [LUT_MODE_W-1:0] mode,
                                         input logic [LUT_IN_W-1:0]   a);
    lut_xlat_t x;
    x.addr = '0;
    x.bs   = '0;
    x.err  = 1'b0;
    case (mode)
      ALG_SPN8: begin
        x.addr = {9'd0, a[7:4]};
        x.bs   = a[3:0];
      end
      ALG_SPN16: begin
        x.addr = a[15:3];
        x.bs   = {1'b0, a[2:0]};
      end
      default: x.err = 1'b1;
    endcase
    return x;
  endfunction

endpackage

// File: rtl/lut_req_arb_rr.sv
// -----------------------------------------------------------------------------
// lut_rr_arb2
// Two-request round-robin arbiter with one-hot grant.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : grants are only issued while high
//   i_req[1:0]     : request vector
//   o_gnt[1:0]     : one-hot grant (combinational)
// When both request, the one not granted last wins; after reset requester 0
// has priority. A lone request is granted immediately.
// -----------------------------------------------------------------------------
module lut_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Index of the requester that wins a tie next.
  logic       r_prio;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Priority moves to the other requester after every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (|w_gnt) begin
      r_prio <= w_gnt[0];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/lut_req_arb.sv
// -----------------------------------------------------------------------------
// lut_req_arb
// Fills a LUT RAM from a generation stream, then serves lookups from two
// requesters through a round-robin arbiter with a fixed 1-cycle response.
// Optional feature macro: LUT_ARB_STATS_EN (per-requester grant counters).
// Ports:
//   i_clk, i_rst_n               : clock, asynchronous active-low reset
//   i_gen_start, i_alg_mode      : start generation, latch algorithm mode
//   i_gen_valid/o_gen_ready      : generation data handshake, i_gen_data word
//   o_gen_done                   : pulse on the GEN_LAST write
//   i_req_valid/o_req_ready[1:0] : lookup handshake, i_req_addr0/1 inputs
//   o_ram_en/we/addr/wdata       : RAM port, i_ram_rdata 1 cycle after read
//   o_rsp_valid/id/err/d8/d16    : lookup response
//   o_stat_gnt0/1                : grant counters (0 when feature disabled)
// -----------------------------------------------------------------------------
module lut_req_arb
  import lut_req_arb_pkg::*;
#(
  parameter logic [LUT_ADDR_W-1:0] GEN_LAST = 13'h1FFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_gen_start,
  input  logic [LUT_MODE_W-1:0] i_alg_mode,
  input  logic                  i_gen_valid,
  output logic                  o_gen_ready,
  input  logic [LUT_DATA_W-1:0] i_gen_data,
  output logic                  o_gen_done,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [LUT_IN_W-1:0]   i_req_addr0,
  input  logic [LUT_IN_W-1:0]   i_req_addr1,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [LUT_ADDR_W-1:0] o_ram_addr,
  output logic [LUT_DATA_W-1:0] o_ram_wdata,
  input  logic [LUT_DATA_W-1:0] i_ram_rdata,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_id,
  output logic                  o_rsp_err,
  output logic [7:0]            o_rsp_d8,
  output logic [15:0]           o_rsp_d16,
  output logic [LUT_STAT_W-1:0] o_stat_gnt0,
  output logic [LUT_STAT_W-1:0] o_stat_gnt1
);

  lut_state_e            r_state, w_state_next;
  logic [LUT_ADDR_W-1:0] r_cnt, w_cnt_next;
  logic [LUT_MODE_W-1:0] r_cfg_mode, w_cfg_mode_next;

  logic                  w_in_gen;
  logic                  w_wr;
  logic                  w_gen_accept;
  logic [1:0]            w_gnt;
  logic                  w_any_gnt;
  logic [LUT_IN_W-1:0]   w_sel_in;
  lut_xlat_t             w_xlat;

  logic                  r_rsp_valid;
  logic                  r_rsp_id;
  logic                  r_rsp_err;
  logic [3:0]            r_bs;

  assign w_in_gen     = (r_state == ST_GEN);
  assign w_wr         = w_in_gen & i_gen_valid;
  assign w_gen_accept = i_gen_start & ~w_in_gen;

  // ---------------------------------------------------------------------------
  // FSM, write counter and mode register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_cfg_mode_next = r_cfg_mode;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (i_gen_start) begin
          w_state_next    = ST_GEN;
          w_cnt_next      = '0;
          w_cfg_mode_next = i_alg_mode;
        end
      end
      ST_GEN: begin
        if (i_gen_valid) begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == GEN_LAST) begin
            w_state_next = ST_RUN;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cfg_mode <= ALG_SPN8;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_cfg_mode <= w_cfg_mode_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup arbitration. Grants continue in the RUN cycle that accepts
  // gen_start; that read still completes while the FSM is in GEN.
  // ---------------------------------------------------------------------------
  lut_rr_arb2 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_state == ST_RUN),
    .i_req   (i_req_valid),
    .o_gnt   (w_gnt)
  );

  assign w_any_gnt = |w_gnt;
  assign w_sel_in  = w_gnt[1] ? i_req_addr1 : i_req_addr0;
  assign w_xlat    = lut_xlat(r_cfg_mode, w_sel_in);

  // ---------------------------------------------------------------------------
  // RAM port: writes only in GEN, reads only in RUN, so they never collide.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ram_addr = '0;
    if (w_wr) begin
      o_ram_addr = r_cnt;
    end else if (w_any_gnt) begin
      o_ram_addr = w_xlat.addr;
    end
  end

  assign o_ram_en    = w_wr | w_any_gnt;
  assign o_ram_we    = w_wr;
  assign o_ram_wdata = i_gen_data;
  assign o_gen_ready = w_in_gen;
  assign o_gen_done  = w_wr & (r_cnt == GEN_LAST);
  assign o_req_ready = w_gnt;

  // ---------------------------------------------------------------------------
  // Response pipeline: capture select/id/err at grant, pick data next cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_bs        <= '0;
    end else begin
      r_rsp_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_rsp_id  <= w_gnt[1];
        r_rsp_err <= w_xlat.err;
        r_bs      <= w_xlat.bs;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_d8    = i_ram_rdata[{r_bs, 3'b000} +: 8];
  assign o_rsp_d16   = i_ram_rdata[{r_bs[2:0], 4'b0000} +: 16];

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef LUT_ARB_STATS_EN
  logic [LUT_STAT_W-1:0] r_stat [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_stat[gi] <= '0;
        end else if (w_gen_accept) begin
          r_stat[gi] <= '0;
        end else if (w_gnt[gi] && (r_stat[gi] != {LUT_STAT_W{1'b1}})) begin
          r_stat[gi] <= r_stat[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign o_stat_gnt0 = r_stat[0];
  assign o_stat_gnt1 = r_stat[1];
`else
  // Accept-strobe only feeds the counters; keep it referenced when absent.
  logic w_unused_accept;
  assign w_unused_accept = w_gen_accept;
  assign o_stat_gnt0     = '0;
  assign o_stat_gnt1     = '0;
`endif

endmodule

// File: tb/tb_lut_req_arb.sv
// -----------------------------------------------------------------------------
// tb_lut_req_arb
// Directed bench for lut_req_arb with GEN_LAST = 3. RAM read data is a fixed
// pattern so every selected byte/halfword has a known hand-computed value.
// -----------------------------------------------------------------------------
module tb_lut_req_arb;

  logic         clk;
  logic         rst_n;
  logic         gen_start;
  logic [2:0]   alg_mode;
  logic         gen_valid;
  logic         gen_ready;
  logic [127:0] gen_data;
  logic         gen_done;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [15:0]  req_addr0;
  logic [15:0]  req_addr1;
  logic         ram_en;
  logic         ram_we;
  logic [12:0]  ram_addr;
  logic [127:0] ram_wdata;
  logic [127:0] ram_rdata;
  logic         rsp_valid;
  logic         rsp_id;
  logic         rsp_err;
  logic [7:0]   rsp_d8;
  logic [15:0]  rsp_d16;
  logic [15:0]  stat_gnt0;
  logic [15:0]  stat_gnt1;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LUT_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // byte0=FF byte1=EE byte2=DD byte7=88 halfword5=4455
  localparam logic [127:0] RDATA = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  lut_req_arb #(.GEN_LAST(13'd3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_gen_start (gen_start),
    .i_alg_mode  (alg_mode),
    .i_gen_valid (gen_valid),
    .o_gen_ready (gen_ready),
    .i_gen_data  (gen_data),
    .o_gen_done  (gen_done),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr0 (req_addr0),
    .i_req_addr1 (req_addr1),
    .o_ram_en    (ram_en),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_err   (rsp_err),
    .o_rsp_d8    (rsp_d8),
    .o_rsp_d16   (rsp_d16),
    .o_stat_gnt0 (stat_gnt0),
    .o_stat_gnt1 (stat_gnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] dword(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + k;
    return {4{w}};
  endfunction

  // Four generation beats starting in GEN; returns with FSM in RUN.
  task automatic gen_beats();
    for (int k = 0; k < 4; k++) begin
      gen_valid = 1'b1;
      gen_data  = dword(k);
      #1;
      chk("gen_wr_addr", ram_addr, k);
      chk("gen_done", gen_done, (k == 3));
      tick();
    end
    gen_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    gen_start = 1'b0;
    alg_mode  = 3'b000;
    gen_valid = 1'b0;
    gen_data  = '0;
    req_valid = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    ram_rdata = RDATA;

    // Reset state
    tick();
    tick();
    req_valid = 2'b11;
    #1;
    chk("rst_gen_ready", gen_ready, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_gen_done", gen_done, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_stat0", stat_gnt0, 16'd0);
    chk("rst_stat1", stat_gnt1, 16'd0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;

    // Generation in spn8, with ignored gen_start and lookups during GEN
    tick();
    gen_start = 1'b1;
    alg_mode  = 3'b000;
    #1;
    chk("idle_gen_ready", gen_ready, 1'b0);
    tick();
    gen_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gen_valid = 1'b1;
      gen_data  = dword(k);
      req_valid = (k == 1) ? 2'b11 : 2'b00;
      gen_start = (k == 2);
      #1;
      chk("gen_ready", gen_ready, 1'b1);
      chk("gen_ram_en", ram_en, 1'b1);
      chk("gen_ram_we", ram_we, 1'b1);
      chk("gen_addr", ram_addr, k);
      chk("gen_wdata", ram_wdata, dword(k));
      chk("gen_done_pulse", gen_done, (k == 3));
      chk("gen_no_grant", req_ready, 2'b00);
      tick();
    end
    gen_valid = 1'b0;
    gen_start = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("run_gen_ready", gen_ready, 1'b0);
    chk("run_gen_done", gen_done, 1'b0);

    // Round-robin with both valid: grants 0,1,0,1
    req_addr0 = 16'h0011;
    req_addr1 = 16'h0022;
    req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rr_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_ram_addr", ram_addr, (c % 2 == 0) ? 13'h001 : 13'h002);
      chk("rr_ram_we", ram_we, 1'b0);
      if (c == 0) begin
        chk("rr_first_rsp", rsp_valid, 1'b0);
      end else begin
        chk("rr_rsp_valid", rsp_valid, 1'b1);
        chk("rr_rsp_id", rsp_id, ((c - 1) % 2));
        chk("rr_rsp_d8", rsp_d8, ((c - 1) % 2 == 0) ? 8'hEE : 8'hDD);
      end
      tick();
    end
    req_valid = 2'b00;
    #1;
    chk("rr_last_rsp_valid", rsp_valid, 1'b1);
    chk("rr_last_rsp_id", rsp_id, 1'b1);
    chk("rr_last_rsp_d8", rsp_d8, 8'hDD);
    chk("rr_idle_ram_en", ram_en, 1'b0);
    chk("rr_stat0", stat_gnt0, STATS ? 16'd2 : 16'd0);
    chk("rr_stat1", stat_gnt1, STATS ? 16'd2 : 16'd0);
    tick();
    #1;
    chk("rr_rsp_drop", rsp_valid, 1'b0);

    // spn8 single lookup
    req_valid = 2'b01;
    req_addr0 = 16'h00A7;
    #1;
    chk("spn8_ready", req_ready, 2'b01);
    chk("spn8_ram_addr", ram_addr, 13'h00A);
    chk("spn8_ram_en", ram_en, 1'b1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("spn8_rsp_valid", rsp_valid, 1'b1);
    chk("spn8_rsp_id", rsp_id, 1'b0);
    chk("spn8_rsp_err", rsp_err, 1'b0);
    chk("spn8_rsp_d8", rsp_d8, 8'h88);
    tick();

    // gen_start in RUN alongside a grant; switch to spn16
    gen_start = 1'b1;
    alg_mode  = 3'b001;
    req_valid = 2'b01;
    #1;
    chk("inflight_ready", req_ready, 2'b01);
    chk("inflight_addr", ram_addr, 13'h00A);
    tick();
    gen_start = 1'b0;
    #1;
    chk("inflight_rsp_valid", rsp_valid, 1'b1);
    chk("inflight_rsp_id", rsp_id, 1'b0);
    chk("inflight_rsp_d8", rsp_d8, 8'h88);
    chk("inflight_gen_ready", gen_ready, 1'b1);
    chk("inflight_no_grant", req_ready, 2'b00);
    chk("inflight_ram_en", ram_en, 1'b0);
    req_valid = 2'b00;
    gen_beats();

    // spn16 lookup from requester 1
    req_valid = 2'b10;
    req_addr1 = 16'h1235;
    #1;
    chk("spn16_ready", req_ready, 2'b10);
    chk("spn16_ram_addr", ram_addr, 13'h0246);
    tick();
    req_valid = 2'b00;
    #1;
    chk("spn16_rsp_valid", rsp_valid, 1'b1);
    chk("spn16_rsp_id", rsp_id, 1'b1);
    chk("spn16_rsp_err", rsp_err, 1'b0);
    chk("spn16_rsp_d16", rsp_d16, 16'h4455);
    tick();

    // Unsupported mode
    gen_start = 1'b1;
    alg_mode  = 3'b101;
    tick();
    gen_start = 1'b0;
    gen_beats();
    req_valid = 2'b01;
    req_addr0 = 16'hFFFF;
    #1;
    chk("bad_ready", req_ready, 2'b01);
    chk("bad_ram_addr", ram_addr, 13'h0000);
    chk("bad_ram_en", ram_en, 1'b1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("bad_rsp_valid", rsp_valid, 1'b1);
    chk("bad_rsp_err", rsp_err, 1'b1);
    tick();

    // Reset mid-GEN
    gen_start = 1'b1;
    alg_mode  = 3'b000;
    tick();
    gen_start = 1'b0;
    gen_valid = 1'b1;
    gen_data  = dword(0);
    #1;
    chk("midgen_addr0", ram_addr, 13'd0);
    tick();
    #1;
    chk("midgen_addr1", ram_addr, 13'd1);
    chk("midgen_gen_ready", gen_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_gen_ready", gen_ready, 1'b0);
    chk("arst_ram_en", ram_en, 1'b0);
    chk("arst_ram_we", ram_we, 1'b0);
    chk("arst_ram_addr", ram_addr, 13'd0);
    chk("arst_gen_done", gen_done, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    tick();
    rst_n     = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("post_rst_gen_ready", gen_ready, 1'b0);
    chk("post_rst_ram_en", ram_en, 1'b0);
    chk("post_rst_req_ready", req_ready, 2'b00);
    chk("post_rst_stat0", stat_gnt0, 16'd0);
    tick();
    #1;
    chk("post_rst_gen_done", gen_done, 1'b0);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    gen_valid = 1'b0;
    req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lut_req_arb.md
LUT_REQ_ARB -- requirements
Module: lut_req_arb

Interface
REQ-001 Parameter GEN_LAST, default 13'h1FFF; last LUT RAM word address written during generation.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 gen_start  in  1  one-cycle pulse; begin LUT generation and latch alg_mode.
REQ-005 alg_mode  in  3  000 spn8, 001 spn16, others unsupported; sampled only on accepted gen_start.
REQ-006 gen_valid / gen_ready  in/out  1/1  generation-data handshake.
REQ-007 gen_data  in  128  LUT word to write.
REQ-008 gen_done  out  1  one-cycle pulse when the GEN_LAST word is written.
REQ-009 req_valid[1:0] / req_ready[1:0]  in/out  2/2  per-requester lookup handshake.
REQ-010 req_addr0, req_addr1  in  16  per-requester lookup input value.
REQ-011 ram_en, ram_we  out  1/1  RAM access strobe and write enable.
REQ-012 ram_addr  out  13  RAM word address.
REQ-013 ram_wdata  out  128  RAM write data, equal to gen_data.
REQ-014 ram_rdata  in  128  RAM read data, valid exactly one cycle after a read strobe.
REQ-015 rsp_valid, rsp_id, rsp_err  out  1/1/1  lookup response strobe, requester index, unsupported-mode flag.
REQ-016 rsp_d8, rsp_d16  out  8/16  selected byte and halfword.
REQ-017 stat_gnt0, stat_gnt1  out  16/16  grant counters (see Configuration).

Function
REQ-018 FSM states: IDLE, GEN, RUN; reset state IDLE.
REQ-019 IDLE or RUN + gen_start -> GEN next cycle; cfg_mode <= alg_mode; address counter <= 0; gen_start in GEN is ignored.
REQ-020 GEN: gen_ready=1; on gen_valid: ram_en=ram_we=1, ram_addr=counter, counter+1; write at counter==GEN_LAST -> RUN with gen_done pulse in the same cycle as that write.
REQ-021 req_ready is 0 outside RUN; in RUN, exactly one requester is granted per cycle, and only when its req_valid is 1.
REQ-022 Arbitration is round-robin: with both valid, grant the requester not granted last; pointer reset favours requester 0; single valid is granted immediately.
REQ-023 Grant: ram_en=1, ram_we=0, ram_addr/bs from cfg_mode: spn8 addr={9'd0,a[7:4]}, bs=a[3:0]; spn16 addr=a[15:3], bs={1'b0,a[2:0]}; other addr=0, bs=0, err=1.
REQ-024 bs, id and err are registered at grant; next cycle rsp_valid=1 with rsp_id/rsp_err, rsp_d8=ram_rdata byte bs, rsp_d16=ram_rdata halfword bs[2:0]; latency exactly 1 cycle.
REQ-025 The response interface has no backpressure; back-to-back grants produce back-to-back responses.
REQ-026 A read granted in the cycle gen_start arrives still returns its response in the following cycle (in GEN); no lookups are granted in GEN.
REQ-027 rsp_d8/rsp_d16 are don't-care when rsp_valid=0; ram_en=0 when no write or grant occurs.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, counter 0, cfg_mode 000, RR pointer to requester 0, rsp_valid 0, gen_done 0, ram_en/ram_we 0, stat counters 0.
REQ-029 Reset mid-GEN or with a read in flight discards the operation; no response or gen_done follows.

Configuration
REQ-030 With LUT_ARB_STATS_EN defined, stat_gnt0/1 count grants per requester, saturating at 16'hFFFF, cleared on reset and on accepted gen_start.
REQ-031 Without LUT_ARB_STATS_EN, stat_gnt0/1 are constant 0 and no counter logic exists.

Structure
REQ-032 A shared package holds the alg_mode encodings (SPN8=3'b000, SPN16=3'b001), the FSM state enum and width constants (addr 13, data 128).
REQ-033 The round-robin arbiter is a separate sub-module, lut_rr_arb2 (2 requests, grant one-hot, pointer update on grant).

Verification
REQ-034 GEN_LAST=3, gen_start, 4 gen_valid beats with data D0..D3 -> writes to addr 0..3 and gen_done pulsing on the addr-3 write; state RUN.
REQ-035 spn8, req0 addr 16'h00A7 -> ram_addr 13'h00A, bs 7; next cycle rsp_valid, rsp_id 0, rsp_d8=ram_rdata[63:56].
REQ-036 spn16, req1 addr 16'h1235 -> ram_addr 13'h0246; next cycle rsp_d16=ram_rdata[95:80], rsp_id 1.
REQ-037 Both requesters valid for 4 cycles after reset -> grants 0,1,0,1, four consecutive responses; with LUT_ARB_STATS_EN, stat_gnt0=stat_gnt1=2.
REQ-038 alg_mode 3'b101 -> lookup returns rsp_err=1, ram_addr 0; gen_start during RUN with a grant in flight -> that response still appears next cycle and req_ready stays 0 in GEN.
REQ-039 rst_n asserted mid-GEN -> all outputs at reset values in the same cycle, no gen_done, state IDLE.
